// File: rtl/rom_load_sequencer.sv
`default_nettype none
// ============================================================================
// rom_load_sequencer: routes the HPS ioctl ROM stream to four ROM regions and
// holds the Sprint 2 core in reset during and shortly after the download.
// Revision: 1.0
// ============================================================================
module rom_load_sequencer #(
  parameter logic [16:0] R0_BASE     = 17'h00000,
  parameter logic [16:0] R1_BASE     = 17'h02000,
  parameter logic [16:0] R2_BASE     = 17'h02800,
  parameter logic [16:0] R3_BASE     = 17'h03000,
  parameter logic [16:0] END_ADDR    = 17'h03200,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [3:0]  rom_we,
  output logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        busy,
  output logic        loaded,
  output logic [16:0] byte_count,
  output logic [7:0]  checksum,
  output logic        oob_err
);

  localparam int unsigned      CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]    HOLD_LOAD = CW'(HOLD_CYCLES);
  localparam logic [16:0]      COUNT_MAX = 17'h1FFFF;
  // Ascending region boundaries; entry i+1 is the exclusive end of region i.
  localparam logic [4:0][16:0] BOUNDS    = {END_ADDR, R3_BASE, R2_BASE, R1_BASE, R0_BASE};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] hold_q;
  logic [3:0]    rom_we_q;
  logic [16:0]   rom_addr_q;
  logic [7:0]    rom_data_q;
  logic          core_reset_q;
  logic          busy_q;
  logic          loaded_q;
  logic [16:0]   byte_count_q, byte_count_d;
  logic [7:0]    checksum_q, checksum_d;
  logic          oob_q, oob_d;

  logic [16:0]   addr_lo;
  logic          addr_hi_ok;
  logic [4:0]    ge;
  logic [3:0]    hit;
  logic [16:0]   offset;
  logic [17:0]   diff;
  logic          accept;
  logic          start;
  logic          write_ok;

  assign addr_lo    = ioctl_addr[16:0];
  assign addr_hi_ok = (ioctl_addr[24:17] == 8'd0);

  // Borrow-based compares avoid constant-folded "x >= 0" tests when R0_BASE is 0.
  always_comb begin
    ge     = '0;
    hit    = '0;
    offset = '0;
    diff   = '0;
    for (int i = 0; i < 5; i++) begin
      diff  = {1'b0, addr_lo} - {1'b0, BOUNDS[i]};
      ge[i] = ~diff[17];
    end
    for (int i = 0; i < 4; i++) begin
      hit[i] = addr_hi_ok & ge[i] & ~ge[i+1];
      if (hit[i]) begin
        offset = addr_lo - BOUNDS[i];
      end
    end
  end

  assign accept   = ioctl_wr & ioctl_download;
  assign start    = ioctl_download & (state_q != S_LOAD);
  assign write_ok = accept & (|hit);

  // A byte on the entry cycle counts against the freshly cleared statistics.
  always_comb begin
    byte_count_d = start ? 17'd0 : byte_count_q;
    checksum_d   = start ? 8'd0  : checksum_q;
    oob_d        = start ? 1'b0  : oob_q;
    if (write_ok) begin
      if (byte_count_d != COUNT_MAX) begin
        byte_count_d = byte_count_d + 17'd1;
      end
      checksum_d = checksum_d + ioctl_dout;
    end else if (accept) begin
      oob_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      rom_we_q     <= 4'd0;
      rom_addr_q   <= 17'd0;
      rom_data_q   <= 8'd0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      loaded_q     <= 1'b0;
      byte_count_q <= 17'd0;
      checksum_q   <= 8'd0;
      oob_q        <= 1'b0;
    end else begin
      rom_we_q     <= write_ok ? hit : 4'd0;
      if (write_ok) begin
        rom_addr_q <= offset;
        rom_data_q <= ioctl_dout;
      end
      byte_count_q <= byte_count_d;
      checksum_q   <= checksum_d;
      oob_q        <= oob_d;

      case (state_q)
        S_IDLE: begin
          if (ioctl_download) begin
            state_q  <= S_LOAD;
            busy_q   <= 1'b1;
            loaded_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!ioctl_download) begin
            state_q <= S_HOLD;
            hold_q  <= HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (ioctl_download) begin
            state_q  <= S_LOAD;
            loaded_q <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
            if (hold_q == {{(CW-1){1'b0}}, 1'b1}) begin
              busy_q   <= 1'b0;
              loaded_q <= (byte_count_q == END_ADDR) && !oob_q;
              if (byte_count_q == 17'd0) begin
                state_q <= S_IDLE;
              end else begin
                state_q      <= S_RUN;
                core_reset_q <= 1'b0;
              end
            end
          end
        end
        S_RUN: begin
          if (ioctl_download) begin
            state_q      <= S_LOAD;
            busy_q       <= 1'b1;
            loaded_q     <= 1'b0;
            core_reset_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          core_reset_q <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign loaded     = loaded_q;
  assign byte_count = byte_count_q;
  assign checksum   = checksum_q;
  assign oob_err    = oob_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_load_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rom_load_sequencer: directed vector bench for rom_load_sequencer.
// Revision: 1.0
// ============================================================================
module tb_rom_load_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [3:0]  rom_we;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset;
  logic        busy;
  logic        loaded;
  logic [16:0] byte_count;
  logic [7:0]  checksum;
  logic        oob_err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_sys = ~clk_sys;

  rom_load_sequencer #(.HOLD_CYCLES(16)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .rom_we         (rom_we),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .core_reset     (core_reset),
    .busy           (busy),
    .loaded         (loaded),
    .byte_count     (byte_count),
    .checksum       (checksum),
    .oob_err        (oob_err)
  );

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [3:0]  we;
    logic [16:0] raddr;
    logic [7:0]  rdata;
    logic [16:0] cnt;
    logic [7:0]  sum;
    logic        oob;
  } vec_t;

  vec_t vt [12];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller has already dropped ioctl_download; counts edges until core_reset falls.
  task automatic wait_fall(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (core_reset === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(name, n, exp_cycles);
  endtask

  initial begin
    int bad;
    int cr_low;
    int drop_at;
    logic [3:0]  e_we;
    logic [16:0] e_a;

    vt[0]  = '{25'h0000000, 8'h11, 4'b0001, 17'h0000, 8'h11, 17'd1, 8'h11, 1'b0};
    vt[1]  = '{25'h0001FFF, 8'h22, 4'b0001, 17'h1FFF, 8'h22, 17'd2, 8'h33, 1'b0};
    vt[2]  = '{25'h0002000, 8'h33, 4'b0010, 17'h0000, 8'h33, 17'd3, 8'h66, 1'b0};
    vt[3]  = '{25'h00027FF, 8'h44, 4'b0010, 17'h07FF, 8'h44, 17'd4, 8'hAA, 1'b0};
    vt[4]  = '{25'h0002800, 8'h55, 4'b0100, 17'h0000, 8'h55, 17'd5, 8'hFF, 1'b0};
    vt[5]  = '{25'h0002FFF, 8'h66, 4'b0100, 17'h07FF, 8'h66, 17'd6, 8'h65, 1'b0};
    vt[6]  = '{25'h0003000, 8'h77, 4'b1000, 17'h0000, 8'h77, 17'd7, 8'hDC, 1'b0};
    vt[7]  = '{25'h00031FF, 8'h88, 4'b1000, 17'h01FF, 8'h88, 17'd8, 8'h64, 1'b0};
    vt[8]  = '{25'h0003200, 8'h99, 4'b0000, 17'h01FF, 8'h88, 17'd8, 8'h64, 1'b1};
    vt[9]  = '{25'h1000000, 8'hAA, 4'b0000, 17'h01FF, 8'h88, 17'd8, 8'h64, 1'b1};
    vt[10] = '{25'h0020005, 8'hBB, 4'b0000, 17'h01FF, 8'h88, 17'd8, 8'h64, 1'b1};
    vt[11] = '{25'h001FFFF, 8'hCC, 4'b0000, 17'h01FF, 8'h88, 17'd8, 8'h64, 1'b1};

    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    tick(); tick();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_data", rom_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_oob", oob_err, 0);
    reset = 1'b0;
    tick();
    chk("idle_core_reset", core_reset, 1);

    // Decode table: download rises together with the first write.
    for (int i = 0; i < 12; i++) begin
      ioctl_download = 1'b1; ioctl_wr = 1'b1;
      ioctl_addr = vt[i].addr; ioctl_dout = vt[i].data;
      tick();
      chk($sformatf("v%0d_we", i), rom_we, vt[i].we);
      chk($sformatf("v%0d_addr", i), rom_addr, vt[i].raddr);
      chk($sformatf("v%0d_data", i), rom_data, vt[i].rdata);
      chk($sformatf("v%0d_cnt", i), byte_count, vt[i].cnt);
      chk($sformatf("v%0d_sum", i), checksum, vt[i].sum);
      chk($sformatf("v%0d_oob", i), oob_err, vt[i].oob);
    end
    ioctl_download = 1'b0; ioctl_wr = 1'b0;
    wait_fall("tbl_core_reset_fall", 17);
    chk("tbl_loaded", loaded, 0);
    chk("tbl_oob", oob_err, 1);
    chk("tbl_busy", busy, 0);
    chk("tbl_cnt", byte_count, 8);

    // Re-download from RUN with a write in the rising cycle.
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'h0002800; ioctl_dout = 8'hA5;
    tick();
    chk("redl_core_reset", core_reset, 1);
    chk("redl_we", rom_we, 4'b0100);
    chk("redl_addr", rom_addr, 0);
    chk("redl_cnt", byte_count, 1);
    chk("redl_sum", checksum, 8'hA5);
    chk("redl_oob_clr", oob_err, 0);
    chk("redl_busy", busy, 1);
    ioctl_download = 1'b0; ioctl_wr = 1'b0;
    wait_fall("redl_core_reset_fall", 17);
    chk("redl_loaded", loaded, 0);

    // Full image, data = addr[7:0].
    bad = 0;
    for (int i = 0; i < 32'h3200; i++) begin
      ioctl_download = 1'b1; ioctl_wr = 1'b1;
      ioctl_addr = 25'(i); ioctl_dout = i[7:0];
      tick();
      if (i < 32'h2000)      begin e_we = 4'b0001; e_a = 17'(i); end
      else if (i < 32'h2800) begin e_we = 4'b0010; e_a = 17'(i - 32'h2000); end
      else if (i < 32'h3000) begin e_we = 4'b0100; e_a = 17'(i - 32'h2800); end
      else                   begin e_we = 4'b1000; e_a = 17'(i - 32'h3000); end
      if (rom_we !== e_we || rom_addr !== e_a || rom_data !== i[7:0]) bad++;
      if (core_reset !== 1'b1 || busy !== 1'b1) bad++;
    end
    chk("full_stream_bad", bad, 0);
    chk("full_cnt_streaming", byte_count, 17'h3200);
    ioctl_download = 1'b0; ioctl_wr = 1'b0;
    tick();
    chk("full_we_single", rom_we, 0);
    chk("full_hold_core_reset", core_reset, 1);
    bad = 1;
    while (core_reset === 1'b1 && bad < 200) begin
      tick();
      bad++;
    end
    chk("full_core_reset_fall", bad, 17);
    chk("full_cnt", byte_count, 17'h3200);
    chk("full_sum", checksum, 8'h00);
    chk("full_loaded", loaded, 1);
    chk("full_oob", oob_err, 0);
    chk("full_busy", busy, 0);

    // Empty download from RUN.
    cr_low = 0;
    ioctl_download = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (core_reset !== 1'b1) cr_low++;
    end
    chk("empty_cnt_clr", byte_count, 0);
    chk("empty_loaded_clr", loaded, 0);
    ioctl_download = 1'b0;
    drop_at = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (core_reset !== 1'b1) cr_low++;
      if (drop_at == 0 && busy === 1'b0) drop_at = i;
    end
    chk("empty_core_reset_low", cr_low, 0);
    chk("empty_busy_drop", drop_at, 17);
    chk("empty_loaded", loaded, 0);

    // Restart during HOLD.
    cr_low = 0;
    for (int i = 0; i < 3; i++) begin
      ioctl_download = 1'b1; ioctl_wr = 1'b1;
      ioctl_addr = 25'(i); ioctl_dout = 8'(i + 1);
      tick();
    end
    chk("rh_cnt_pre", byte_count, 3);
    chk("rh_sum_pre", checksum, 8'h06);
    ioctl_download = 1'b0; ioctl_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (core_reset !== 1'b1) cr_low++;
    end
    ioctl_download = 1'b1;
    tick();
    if (core_reset !== 1'b1) cr_low++;
    chk("rh_cnt_clr", byte_count, 0);
    chk("rh_sum_clr", checksum, 0);
    chk("rh_busy", busy, 1);
    ioctl_wr = 1'b1; ioctl_addr = 25'h0003000; ioctl_dout = 8'h10;
    tick();
    if (core_reset !== 1'b1) cr_low++;
    chk("rh_we", rom_we, 4'b1000);
    chk("rh_cnt", byte_count, 1);
    chk("rh_core_reset_low", cr_low, 0);
    ioctl_download = 1'b0; ioctl_wr = 1'b0;
    wait_fall("rh_core_reset_fall", 17);

    // Reset mid-load with a write pending.
    for (int i = 0; i < 100; i++) begin
      ioctl_download = 1'b1; ioctl_wr = 1'b1;
      ioctl_addr = 25'(32'h100 + i); ioctl_dout = 8'(i);
      tick();
    end
    chk("rml_cnt", byte_count, 100);
    chk("rml_sum", checksum, 8'h56);
    reset = 1'b1; ioctl_addr = 25'h0000200; ioctl_dout = 8'hEE;
    tick();
    chk("rml_we", rom_we, 0);
    chk("rml_cnt_rst", byte_count, 0);
    chk("rml_sum_rst", checksum, 0);
    chk("rml_busy", busy, 0);
    chk("rml_core_reset", core_reset, 1);
    chk("rml_addr", rom_addr, 0);
    reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rom_we !== 4'd0 || busy !== 1'b0 || core_reset !== 1'b1) bad++;
    end
    chk("rml_quiet", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
